instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 6, number of valid instruction-memory words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold request from the downstream stage.
REQ-006 SHALL have port instr_in  input  8  instruction returned combinationally by instruction memory for read_address.
REQ-007 SHALL have port read_address  output  8  current PC, driven directly from the PC register.
REQ-008 SHALL have port ir  output  8  registered instruction for decode.
REQ-009 SHALL have port ir_valid  output  1  ir holds a fetched instruction to be executed.
REQ-010 SHALL have port pc_out  output  8  address from which ir was fetched.
REQ-011 SHALL have port halted  output  1  fetch permanently stopped until reset.

Function
REQ-012 Instruction fields SHALL be op=[7:6], rs=[5:4], rt=[3:2], rd/imm=[1:0]; op 2'b11 is jump with target field [5:0].
REQ-013 FSM states SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-014 BOOT SHALL last exactly one cycle with no capture and ir_valid=0, then go to RUN.
REQ-015 In RUN with stall=0, each edge SHALL load ir<=instr_in, pc_out<=PC, ir_valid<=1, PC<=next_pc; fetch latency is one cycle.
REQ-016 next_pc SHALL be PC+1 (8-bit) for op!=11, and {PC_plus1[7:6], instr_in[5:0]} for op==11.
REQ-017 If the computed next_pc >= MEM_DEPTH, PC SHALL wrap to 8'h00.
REQ-018 In RUN with stall=1, PC, ir, pc_out and ir_valid SHALL hold; no halt detection occurs that cycle.
REQ-019 In HALT, PC, ir and pc_out SHALL hold; ir_valid=0 and halted=1; stall is ignored; only reset exits.
REQ-020 read_address SHALL equal PC at all times, including during BOOT, stall and HALT.

Reset
REQ-021 Asserting reset SHALL immediately, irrespective of clk or state, set PC=PC_RESET, ir=8'h00, pc_out=8'h00, ir_valid=0, halted=0, state=BOOT.
REQ-022 Reset asserted mid-stall or in HALT SHALL discard all held state; fetching restarts from PC_RESET after BOOT.

Configuration
REQ-023 Macro INSTRUCTION_FETCH_HALT_EN SHALL gate self-jump halt detection.
REQ-024 With it defined: a RUN capture with op==11 and jump target == PC SHALL load ir normally (ir_valid=1 for that cycle), then enter HALT on the following edge.
REQ-025 Without it: HALT SHALL be unreachable, halted SHALL be tied 0, and a self-jump refetches the same address indefinitely.

Structure
REQ-026 A shared package fetch_pkg SHALL hold opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11, field-position constants, and the FSM state type.
REQ-027 The combinational next-PC/wrap computation SHALL be one sub-module named next_pc_logic; everything else stays in instruction_fetch.

Verification
REQ-028 Memory 0:8'h44, 1:8'h49, 2:8'h18, 3:8'h89, 4:8'hC3; release reset -> BOOT cycle with ir_valid=0, then pc_out sequence 0,1,2,3,4,3,4,3... with ir matching.
REQ-029 Same program, stall=1 for 3 cycles while pc_out=2 -> ir=8'h18, pc_out=2, read_address=3 held for 3 cycles, then sequence resumes at 3.
REQ-030 MEM_DEPTH=3, all words 8'h00 -> pc_out sequence 0,1,2,0,1,2 (wrap).
REQ-031 With INSTRUCTION_FETCH_HALT_EN, address 4=8'hC4 -> ir=8'hC4, ir_valid=1 for one cycle, then halted=1, ir_valid=0, read_address=4 held; without the macro -> pc_out 4,4,4... with ir_valid=1.
REQ-032 Assert reset asynchronously between clock edges during RUN and during HALT -> all outputs reach reset values before the next edge; after release the REQ-028 sequence repeats from address 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, instruction
// field positions, the fetch FSM state type and small field-extract helpers.
package fetch_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 2;
    localparam int RD_MSB  = 1;
    localparam int RD_LSB  = 0;
    localparam int TGT_MSB = 5;
    localparam int TGT_LSB = 0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] opcode(input logic [7:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] jump_field(input logic [7:0] instr);
        return instr[TGT_MSB:TGT_LSB];
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential increment or in-page jump,
// wrapped to address 0 when it falls outside the populated memory.
module next_pc_logic
    import fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 6
) (
    input  logic [7:0] pc,
    input  logic [7:0] instr,
    output logic [7:0] next_pc
);

    localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

    logic [7:0] pc_plus1;
    logic [7:0] raw_next;

    // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        pc_plus1 = pc + 8'd1;
        raw_next = pc_plus1;
        if (opcode(instr) == OP_J) begin
            // Jumps keep the page bits of the incremented PC.
            raw_next = {pc_plus1[7:6], jump_field(instr)};
        end
        next_pc = ({1'b0, raw_next} >= DEPTH) ? 8'h00 : raw_next;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, PC and fetch registers.
// Optional self-jump halt detection is enabled by INSTRUCTION_FETCH_HALT_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [7:0] PC_RESET  = 8'h00,
    parameter int         MEM_DEPTH = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [7:0] instr_in,
    output logic [7:0] read_address,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic [7:0] pc_out,
    output logic       halted
);

    fetch_state_t state, state_nxt;
    logic [7:0]   pc;
    logic [7:0]   next_pc;
    logic         capture;
    logic         halt_pending;

    next_pc_logic #(.MEM_DEPTH(MEM_DEPTH)) u_next_pc (
        .pc      (pc),
        .instr   (instr_in),
        .next_pc (next_pc)
    );

`ifdef INSTRUCTION_FETCH_HALT_EN
    logic self_jump;

    // Target equals PC only when the increment does not carry out of the page.
    assign self_jump = (opcode(instr_in) == OP_J) &&
                       (jump_field(instr_in) == pc[5:0]) &&
                       (pc[5:0] != 6'h3F);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) halt_pending <= 1'b0;
        else       halt_pending <= capture && self_jump;
    end
`else
    assign halt_pending = 1'b0;
`endif

    assign capture      = (state == RUN) && !stall && !halt_pending;
    assign read_address = pc;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_pending) state_nxt = HALT;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
`ifdef INSTRUCTION_FETCH_HALT_EN
        halted = (state == HALT);
`else
        halted = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_RESET;
            ir       <= 8'h00;
            pc_out   <= 8'h00;
            ir_valid <= 1'b0;
        end else if (capture) begin
            ir       <= instr_in;
            pc_out   <= pc;
            ir_valid <= 1'b1;
            pc       <= next_pc;
        end else if (halt_pending) begin
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program scenarios with
// literal expectations, then randomized programs/stalls/resets vs a fetch model.
module tb_instruction_fetch;

    localparam logic [7:0] PC_RESET  = 8'h00;
    localparam int         MEM_DEPTH = 6;
`ifdef INSTRUCTION_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] instr_in;
    logic [7:0] read_address;
    logic [7:0] ir;
    logic       ir_valid;
    logic [7:0] pc_out;
    logic       halted;

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_err = 0;

    assign instr_in = mem[read_address];

    instruction_fetch #(.PC_RESET(PC_RESET), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .instr_in     (instr_in),
        .read_address (read_address),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .pc_out       (pc_out),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = boot cycle, 1 = fetching, 2 = halted.
    int m_pc = int'(PC_RESET), m_ir = 0, m_pc_out = 0, m_valid = 0;
    int m_phase = 0, m_halt_next = 0;

    always @(posedge clk or posedge reset) begin : model
        int instr, pc1, tgt;
        if (reset) begin
            m_pc = int'(PC_RESET); m_ir = 0; m_pc_out = 0; m_valid = 0;
            m_phase = 0; m_halt_next = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_halt_next != 0) begin
                m_phase = 2; m_valid = 0; m_halt_next = 0;
            end else if (!stall) begin
                instr = int'(mem[m_pc]);
                pc1   = (m_pc + 1) % 256;
                tgt   = ((instr / 64) == 3) ? ((pc1 & 'hC0) | (instr & 'h3F)) : pc1;
                m_ir = instr; m_pc_out = m_pc; m_valid = 1;
                if (HALT_EN && (instr / 64) == 3 && tgt == m_pc) m_halt_next = 1;
                m_pc = (tgt >= MEM_DEPTH) ? 0 : tgt;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("read_address", read_address, 8'(m_pc));
            check("ir",           ir,           8'(m_ir));
            check("pc_out",       pc_out,       8'(m_pc_out));
            check("ir_valid",     {7'd0, ir_valid}, 8'(m_valid));
            check("halted",       {7'd0, halted},   8'(m_phase == 2));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_basic(input logic [7:0] word4);
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[0] = 8'h44; mem[1] = 8'h49; mem[2] = 8'h18; mem[3] = 8'h89; mem[4] = word4;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ra"},     read_address, PC_RESET);
        check({tag, "_ir"},     ir, 8'h00);
        check({tag, "_pc_out"}, pc_out, 8'h00);
        check({tag, "_valid"},  {7'd0, ir_valid}, 8'h00);
        check({tag, "_halted"}, {7'd0, halted}, 8'h00);
    endtask

    // Assumes reset was just released; checks boot cycle then eight fetches.
    task automatic check_basic_seq();
        logic [7:0] ep [8];
        logic [7:0] ei [8];
        ep = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4, 8'd3};
        ei = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3, 8'h89, 8'hC3, 8'h89};
        step();
        check("boot_valid", {7'd0, ir_valid}, 8'h00);
        check("boot_ra", read_address, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step();
            check("seq_pc_out", pc_out, ep[i]);
            check("seq_ir", ir, ei[i]);
            check("seq_valid", {7'd0, ir_valid}, 8'h01);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        reset = 1'b1;
        step();
        step();
        check_reset_values("por");

        // Basic program with a two-instruction loop.
        load_basic(8'hC3);
        reset = 1'b0;
        check_basic_seq();

        // Stall held for three cycles while pc_out = 2.
        reset = 1'b1; step(); reset = 1'b0;
        step(); step(); step(); step();
        check("pre_stall_pc_out", pc_out, 8'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ir", ir, 8'h18);
            check("stall_pc_out", pc_out, 8'd2);
            check("stall_ra", read_address, 8'd3);
            check("stall_valid", {7'd0, ir_valid}, 8'h01);
        end
        stall = 1'b0;
        step();
        check("resume_pc_out", pc_out, 8'd3);
        check("resume_ir", ir, 8'h89);

        // Sequential run off the end of memory wraps to 0.
        reset = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        step(); reset = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            step();
            check("wrap_pc_out", pc_out, 8'(i % MEM_DEPTH));
        end

        // Self-jump at address 4.
        reset = 1'b1; load_basic(8'hC4); step(); reset = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        check("sj_ir", ir, 8'hC4);
        check("sj_valid", {7'd0, ir_valid}, 8'h01);
        check("sj_pc_out", pc_out, 8'd4);
        for (int i = 0; i < 4; i++) begin
            stall = (i == 1);
            step();
            check("sj_ra", read_address, 8'd4);
            check("sj_hold_ir", ir, 8'hC4);
            check("sj_hold_pc_out", pc_out, 8'd4);
            check("sj_halted", {7'd0, halted}, HALT_EN ? 8'h01 : 8'h00);
            check("sj_after_valid", {7'd0, ir_valid}, HALT_EN ? 8'h00 : 8'h01);
        end
        stall = 1'b0;

        // Asynchronous reset between edges while halted / self-looping.
        #1 reset = 1'b1;
        #1 check_reset_values("async_halt");
        step();
        load_basic(8'hC3);
        reset = 1'b0;
        check_basic_seq();

        // Asynchronous reset between edges while running.
        #1 reset = 1'b1;
        #1 check_reset_values("async_run");
        step();
        reset = 1'b0;
        check_basic_seq();

        // Randomized programs, stalls and resets against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                #1 reset = 1'b1;
                step();
                for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
                for (int a = 0; a < 8; a++)
                    if ($urandom_range(0, 3) == 0) mem[a] = {2'b11, 6'(a)};
                reset = 1'b0;
            end
            stall = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
